// File: rtl/add_arbiter.sv
// Two-port arbiter sharing one ripple adder/subtractor. Each granted operation
// walks IDLE -> EXEC -> DONE, with round-robin priority when both ports request.

module ripple_addsub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] b_x;
  logic             carry;

  // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
  // NOTE: blocking assignments are correct here because this is combinational;
  // the carry variable ripples bit by bit within one evaluation.
  always_comb begin
    sum   = '0;
    b_x   = sub ? ~b : b;
    carry = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_x[i] ^ carry;
      carry  = (a[i] & b_x[i]) | (carry & (a[i] ^ b_x[i]));
    end
    cout = carry;
  end
endmodule

module add_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  logic             grant;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             a_msb, b_msb, r_msb;

  ripple_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (opa_q),
    .b   (opb_q),
    .sub (sub_q),
    .sum (sum),
    .cout(cout)
  );

  assign a_msb = opa_q[WIDTH-1];
  assign b_msb = opb_q[WIDTH-1];
  assign r_msb = sum[WIDTH-1];

  // rr_q names the port that wins the next tie; it flips away from every grantee.
  assign grant = (req0 && req1) ? rr_q : req1;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    sub_d    = sub_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          owner_d = grant;
          rr_d    = ~grant;
          sub_d   = grant ? sub1 : sub0;
          opa_d   = grant ? a1 : a0;
          opb_d   = grant ? b1 : b0;
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = sum;
        cf_d     = cout;
        zf_d     = (sum == '0);
        sf_d     = r_msb;
        of_d     = sub_q ? ((a_msb != b_msb) && (r_msb != a_msb))
                         : ((a_msb == b_msb) && (r_msb != a_msb));
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      sub_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      sub_q    <= sub_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  assign done0  = (state_q == DONE) && !owner_q;
  assign done1  = (state_q == DONE) &&  owner_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign sf     = sf_q;
  assign of     = of_q;
endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: drivers push expected results, a monitor
// pops and compares on every done pulse.

module tb_add_arbiter;
  localparam int W = 64;

  typedef struct packed {
    logic         port;
    logic [W-1:0] r;
    logic [3:0]   flags; // {cf, zf, sf, of}
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, cf, zf, sf, of, busy;
  logic [W-1:0] result;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   n_spaced = 0;
  logic spacing_en = 1'b0;

  add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result),
    .cf(cf), .zf(zf), .sf(sf), .of(of), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for done", name);
  endtask

  // Monitor: sample at the falling edge, pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && (done0 || done1)) begin
      exp_t e;
      check("done_exclusive", {63'd0, done0 & done1}, '0);
      check("busy_in_done", {63'd0, busy}, 64'd1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done0=%b done1=%b expected no done", done0, done1);
      end else begin
        e = exp_q.pop_front();
        check("done_port", {63'd0, done1}, {63'd0, e.port});
        check("result", result, e.r);
        check("flags_cf_zf_sf_of", {60'd0, cf, zf, sf, of}, {60'd0, e.flags});
      end
      if (spacing_en) begin
        if (n_spaced > 0) check("done_spacing", 64'(cyc - last_done_cyc), 64'd3);
        n_spaced++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic do_op(input logic port, input logic sub, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_r,
                       input logic [3:0] exp_flags, input logic isolate);
    bit seen = 0;
    exp_q.push_back('{port: port, r: exp_r, flags: exp_flags});
    @(posedge clk); #1;
    if (port) begin a1 = a; b1 = b; sub1 = sub; req1 = 1'b1; end
    else      begin a0 = a; b0 = b; sub0 = sub; req0 = 1'b1; end
    if (isolate) begin
      @(posedge clk); #1;
      if (port) a1 = 64'hDEAD; else a0 = 64'hDEAD;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (port ? done1 : done0) begin seen = 1; break; end
    end
    if (!seen) timeout_fail("op_done");
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_result", result, '0);
    check("reset_flags", {60'd0, cf, zf, sf, of}, '0);
    check("reset_busy_done", {61'd0, busy, done0, done1}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    //     port sub  a                      b                      result                 {cf,zf,sf,of}
    do_op(1'b0, 1'b0, 64'd5,                64'd7,                 64'd12,                4'b0000, 1'b0);
    do_op(1'b1, 1'b1, 64'd3,                64'd3,                 64'd0,                 4'b1100, 1'b0);
    do_op(1'b1, 1'b1, 64'd0,                64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1'b0);
    do_op(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,              64'h8000_0000_0000_0000, 4'b0011, 1'b0);
    do_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,              64'd0,                 4'b1100, 1'b0);
    do_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd1,              64'h7FFF_FFFF_FFFF_FFFF, 4'b1001, 1'b0);
    do_op(1'b1, 1'b1, 64'd5,                64'd9,                 64'hFFFF_FFFF_FFFF_FFFC, 4'b0010, 1'b0);
    // Operand isolation: a0 is overwritten right after the grant edge.
    do_op(1'b0, 1'b0, 64'd100,              64'd23,                64'd123,               4'b0000, 1'b1);

    // Reset during EXEC: abort with every output cleared at once.
    @(posedge clk); #1;
    a0 = 64'd40; b0 = 64'd2; sub0 = 1'b0; req0 = 1'b1;
    @(posedge clk); #2;
    check("busy_in_exec", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_result", result, '0);
    check("abort_flags", {60'd0, cf, zf, sf, of}, '0);
    check("abort_busy_done", {61'd0, busy, done0, done1}, '0);
    req0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    do_op(1'b1, 1'b1, 64'd50, 64'd8, 64'd42, 4'b1000, 1'b0);

    // Contention: both ports request continuously, grants must alternate 0,1,0,1.
    pulse_reset();
    a0 = 64'd10; b0 = 64'd3;  sub0 = 1'b1;
    a1 = 64'd20; b1 = 64'd22; sub1 = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(i[0] ? exp_t'{port: 1'b1, r: 64'd42, flags: 4'b0000}
                           : exp_t'{port: 1'b0, r: 64'd7,  flags: 4'b1000});
    spacing_en = 1'b1;
    n_spaced   = 0;
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    begin
      int dones = 0;
      for (int i = 0; i < 40 && dones < 4; i++) begin
        @(negedge clk);
        if (done0 || done1) dones++;
      end
      if (dones < 4) timeout_fail("contention_done");
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    spacing_en = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), '0);
    check("idle_at_end", {63'd0, busy}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
